// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM states, ALU opcodes and
// bit positions of the captured flags.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      S_GETA  = 3'd0,
      S_GETB  = 3'd1,
      S_GETOP = 3'd2,
      S_EXEC  = 3'd3,
      S_SHOW  = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_NOT = 3'b010,
      OP_AND = 3'b011,
      OP_OR  = 3'b100,
      OP_XOR = 3'b101,
      OP_MAX = 3'b110,
      OP_EQU = 3'b111
   } alu_op_e;

   // Flag vector layout is {carry, overflow, zero, max, equ}
   localparam int unsigned FLG_EQU   = 0;
   localparam int unsigned FLG_MAX   = 1;
   localparam int unsigned FLG_ZERO  = 2;
   localparam int unsigned FLG_OVF   = 3;
   localparam int unsigned FLG_CARRY = 4;
   localparam int unsigned FLG_W     = 5;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce #(
   parameter int unsigned DB_CYCLES = 20000,
   parameter int unsigned DBW       = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_press
);

   localparam logic [DBW-1:0] CNT_MAX = DBW'(DB_CYCLES - 1);

   logic           sync1_q, sync1_d;
   logic           sync2_q, sync2_d;
   logic           db_q, db_d;
   logic           db_prev_q, db_prev_d;
   logic [DBW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d   = i_btn;
      sync2_d   = sync1_q;
      db_d      = db_q;
      db_prev_d = db_q;
      cnt_d     = '0;
      // Any return to the accepted level restarts the stability window
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_MAX) begin
            db_d = sync2_q;
         end else begin
            cnt_d = cnt_q + DBW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         db_q      <= db_d;
         db_prev_q <= db_prev_d;
         cnt_q     <= cnt_d;
      end
   end

   assign o_press = db_q & ~db_prev_q;

endmodule

// File: rtl/alu_cmd_seq.sv
// Operator command sequencer: loads A, B and opcode from switches on button
// presses, presents them to the ALU, then captures result and flags.
module alu_cmd_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 20000,
   parameter int unsigned DBW       = 16,
   parameter int unsigned CNTW      = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_btn,
   input  logic [3:0]      i_sw,
   input  logic [3:0]      i_result,
   input  logic            i_carry,
   input  logic            i_overflow,
   input  logic            i_zero,
   input  logic            i_max,
   input  logic            i_equ,
   output logic [3:0]      o_a,
   output logic [3:0]      o_b,
   output logic [2:0]      o_op,
   output logic [3:0]      o_res_q,
   output logic [4:0]      o_flags_q,
   output logic [2:0]      o_state,
   output logic            o_done,
   output logic [CNTW-1:0] o_cnt
);

   logic press;

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .DBW       (DBW)
   ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (i_btn),
      .o_press (press)
   );

   state_e            state_q, state_d;
   logic [3:0]        a_q, a_d;
   logic [3:0]        b_q, b_d;
   logic [2:0]        op_q, op_d;
   logic [3:0]        res_q, res_d;
   logic [FLG_W-1:0]  flags_q, flags_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      flags_d = flags_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_GETA: begin
            if (press) begin
               a_d     = i_sw;
               state_d = S_GETB;
            end
         end
         S_GETB: begin
            if (press) begin
               b_d     = i_sw;
               state_d = S_GETOP;
            end
         end
         S_GETOP: begin
            if (press) begin
               op_d    = i_sw[2:0];
               state_d = S_EXEC;
            end
         end
         // Operands were registered a full cycle ago, so the ALU output is settled
         S_EXEC: begin
            res_d                = i_result;
            flags_d[FLG_CARRY]   = i_carry;
            flags_d[FLG_OVF]     = i_overflow;
            flags_d[FLG_ZERO]    = i_zero;
            flags_d[FLG_MAX]     = i_max;
            flags_d[FLG_EQU]     = i_equ;
            cnt_d                = cnt_q + CNTW'(1);
            state_d              = S_SHOW;
         end
         S_SHOW: begin
            if (press) begin
               state_d = S_GETA;
            end
         end
         default: state_d = S_GETA;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_GETA;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         flags_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_a       = a_q;
   assign o_b       = b_q;
   assign o_op      = op_q;
   assign o_res_q   = res_q;
   assign o_flags_q = flags_q;
   assign o_state   = state_q;
   assign o_done    = (state_q == S_SHOW);
   assign o_cnt     = cnt_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a behavioural 4-bit ALU closing the loop.
module tb_alu_cmd_seq;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       i_btn = 1'b0;
   logic [3:0] i_sw = '0;
   logic [3:0] alu_res;
   logic       alu_c, alu_v, alu_z, alu_m, alu_e;
   logic [3:0] o_a, o_b, o_res_q;
   logic [2:0] o_op, o_state;
   logic [4:0] o_flags_q;
   logic       o_done;
   logic [7:0] o_cnt;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   alu_cmd_seq #(
      .DB_CYCLES (4),
      .DBW       (16),
      .CNTW      (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_btn      (i_btn),
      .i_sw       (i_sw),
      .i_result   (alu_res),
      .i_carry    (alu_c),
      .i_overflow (alu_v),
      .i_zero     (alu_z),
      .i_max      (alu_m),
      .i_equ      (alu_e),
      .o_a        (o_a),
      .o_b        (o_b),
      .o_op       (o_op),
      .o_res_q    (o_res_q),
      .o_flags_q  (o_flags_q),
      .o_state    (o_state),
      .o_done     (o_done),
      .o_cnt      (o_cnt)
   );

   // Combinational ALU: signed overflow on add/sub forces the result to 0
   logic [4:0] wide;
   logic [3:0] raw;
   always_comb begin
      wide  = '0;
      raw   = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (o_op)
         3'b000: begin
            wide  = {1'b0, o_a} + {1'b0, o_b};
            raw   = wide[3:0];
            alu_c = wide[4];
            alu_v = (o_a[3] == o_b[3]) && (raw[3] != o_a[3]);
         end
         3'b001: begin
            wide  = {1'b0, o_a} - {1'b0, o_b};
            raw   = wide[3:0];
            alu_c = wide[4];
            alu_v = (o_a[3] != o_b[3]) && (raw[3] != o_a[3]);
         end
         3'b010:  raw = ~o_a;
         3'b011:  raw = o_a & o_b;
         3'b100:  raw = o_a | o_b;
         3'b101:  raw = o_a ^ o_b;
         3'b110:  raw = (o_a > o_b) ? o_a : o_b;
         default: raw = {3'b000, o_a == o_b};
      endcase
      alu_res = alu_v ? 4'd0 : raw;
      alu_z   = (alu_res == 4'd0);
      alu_m   = (o_a > o_b);
      alu_e   = (o_a == o_b);
   end

   task automatic press(input logic [3:0] sw);
      i_sw  = sw;
      i_btn = 1'b1;
      repeat (12) @(negedge clk);
      i_btn = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      press(a);
      press(b);
      press({1'b1, op});
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (o_a !== 4'd0) $display("FAIL reset_a: got %0h expected 0", o_a); else passed++;
      checks++; if (o_b !== 4'd0) $display("FAIL reset_b: got %0h expected 0", o_b); else passed++;
      checks++; if (o_op !== 3'd0) $display("FAIL reset_op: got %0h expected 0", o_op); else passed++;
      checks++; if (o_res_q !== 4'd0) $display("FAIL reset_res: got %0h expected 0", o_res_q); else passed++;
      checks++; if (o_flags_q !== 5'd0) $display("FAIL reset_flags: got %0h expected 0", o_flags_q); else passed++;
      checks++; if (o_state !== 3'd0) $display("FAIL reset_state: got %0h expected 0", o_state); else passed++;
      checks++; if (o_done !== 1'b0) $display("FAIL reset_done: got %0h expected 0", o_done); else passed++;
      checks++; if (o_cnt !== 8'd0) $display("FAIL reset_cnt: got %0h expected 0", o_cnt); else passed++;
   endtask

   task automatic test_add_basic;
      bit seen;
      press(4'd3);
      press(4'd2);
      checks++; if (o_state !== 3'd2) $display("FAIL add_getop_state: got %0h expected 2", o_state); else passed++;
      i_sw  = 4'b1000;  // bit 3 must be ignored for the opcode
      i_btn = 1'b1;
      seen  = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (o_state == 3'd3) seen = 1'b1;
      end
      checks++; if (!seen) $display("FAIL add_exec_reached: got state %0h expected 3", o_state); else passed++;
      checks++; if (o_done !== 1'b0) $display("FAIL add_exec_done: got %0h expected 0", o_done); else passed++;
      @(negedge clk);
      checks++; if (o_state !== 3'd4) $display("FAIL add_show_state: got %0h expected 4", o_state); else passed++;
      checks++; if (o_res_q !== 4'd5) $display("FAIL add_res: got %0h expected 5", o_res_q); else passed++;
      checks++; if (o_flags_q !== 5'b00010) $display("FAIL add_flags: got %b expected 00010", o_flags_q); else passed++;
      checks++; if (o_done !== 1'b1) $display("FAIL add_done: got %0h expected 1", o_done); else passed++;
      checks++; if (o_cnt !== 8'd1) $display("FAIL add_cnt: got %0h expected 1", o_cnt); else passed++;
      checks++; if (o_op !== 3'd0) $display("FAIL add_op: got %0h expected 0", o_op); else passed++;
      repeat (12) @(negedge clk);
      i_btn = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (o_state !== 3'd4) $display("FAIL add_held_once: got %0h expected 4", o_state); else passed++;
   endtask

   task automatic test_overflow_equ;
      press(4'd0);
      run_op(4'd7, 4'd1, 3'b000);
      checks++; if (o_res_q !== 4'd0) $display("FAIL ovf_res: got %0h expected 0", o_res_q); else passed++;
      checks++; if (o_flags_q !== 5'b01110) $display("FAIL ovf_flags: got %b expected 01110", o_flags_q); else passed++;
      checks++; if (o_cnt !== 8'd2) $display("FAIL ovf_cnt: got %0h expected 2", o_cnt); else passed++;
      press(4'd0);
      run_op(4'd5, 4'd5, 3'b111);
      checks++; if (o_flags_q[FLG_EQU] !== 1'b1) $display("FAIL equ_flag: got %0h expected 1", o_flags_q[FLG_EQU]); else passed++;
      checks++; if (o_res_q !== 4'd1) $display("FAIL equ_res: got %0h expected 1", o_res_q); else passed++;
      checks++; if (o_cnt !== 8'd3) $display("FAIL equ_cnt: got %0h expected 3", o_cnt); else passed++;
   endtask

   task automatic test_bounce;
      for (int k = 0; k < 10; k++) begin
         i_btn = ~i_btn;
         repeat (2) @(negedge clk);
      end
      i_btn = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (o_state !== 3'd4) $display("FAIL bounce_state: got %0h expected 4", o_state); else passed++;
      i_btn = 1'b1;
      repeat (100) @(negedge clk);
      checks++; if (o_state !== 3'd0) $display("FAIL hold_state: got %0h expected 0", o_state); else passed++;
      i_btn = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (o_state !== 3'd0) $display("FAIL hold_release_state: got %0h expected 0", o_state); else passed++;
   endtask

   task automatic test_async_reset;
      press(4'd9);
      press(4'd1);
      checks++; if (o_a !== 4'd9) $display("FAIL arst_pre_a: got %0h expected 9", o_a); else passed++;
      checks++; if (o_state !== 3'd2) $display("FAIL arst_pre_state: got %0h expected 2", o_state); else passed++;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (o_state !== 3'd0) $display("FAIL arst_state: got %0h expected 0", o_state); else passed++;
      checks++; if (o_a !== 4'd0) $display("FAIL arst_a: got %0h expected 0", o_a); else passed++;
      checks++; if (o_b !== 4'd0) $display("FAIL arst_b: got %0h expected 0", o_b); else passed++;
      checks++; if (o_cnt !== 8'd0) $display("FAIL arst_cnt: got %0h expected 0", o_cnt); else passed++;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_wrap_hold;
      for (int i = 0; i < 256; i++) begin
         logic [3:0] av;
         av = i[3:0];
         run_op(av, 4'd2, 3'b000);
         if (i == 254) begin
            checks++; if (o_cnt !== 8'd255) $display("FAIL wrap_cnt255: got %0h expected ff", o_cnt); else passed++;
         end
         if (i < 255) press(4'd0);
      end
      checks++; if (o_cnt !== 8'd0) $display("FAIL wrap_cnt0: got %0h expected 0", o_cnt); else passed++;
      checks++; if (o_res_q !== 4'd1) $display("FAIL wrap_res: got %0h expected 1", o_res_q); else passed++;
      checks++; if (o_flags_q !== 5'b10010) $display("FAIL wrap_flags: got %b expected 10010", o_flags_q); else passed++;
      i_sw = 4'd6;
      repeat (5) @(negedge clk);
      i_sw = 4'd12;
      repeat (15) @(negedge clk);
      checks++; if (o_res_q !== 4'd1) $display("FAIL show_hold_res: got %0h expected 1", o_res_q); else passed++;
      checks++; if (o_flags_q !== 5'b10010) $display("FAIL show_hold_flags: got %b expected 10010", o_flags_q); else passed++;
      checks++; if (o_a !== 4'd15) $display("FAIL show_hold_a: got %0h expected f", o_a); else passed++;
      checks++; if (o_done !== 1'b1) $display("FAIL show_hold_done: got %0h expected 1", o_done); else passed++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_add_basic();
      test_overflow_equ();
      test_bounce();
      test_async_reset();
      test_wrap_hold();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
